// File: rtl/alb_mp_seq_if.sv
// Command, operand and result handshake bundle between alb_mp_seq and its neighbours.
// master = upstream/downstream environment side, slave = the sequencer.
interface alb_mp_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 4
);
  localparam int WCNT_W = $clog2(MAX_WORDS + 1);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic                  cmd_ci;
  logic [WCNT_W-1:0]     cmd_words;

  logic                  opnd_valid;
  logic                  opnd_ready;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_f;
  logic                  res_last;
  logic                  res_co;
  logic                  res_vo;
  logic                  res_no;
  logic                  res_zo;

  modport master (
    output cmd_valid, cmd_op, cmd_ci, cmd_words,
    output opnd_valid, opnd_a, opnd_b,
    output res_ready,
    input  cmd_ready, opnd_ready,
    input  res_valid, res_f, res_last, res_co, res_vo, res_no, res_zo
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ci, cmd_words,
    input  opnd_valid, opnd_a, opnd_b,
    input  res_ready,
    output cmd_ready, opnd_ready,
    output res_valid, res_f, res_last, res_co, res_vo, res_no, res_zo
  );
endinterface

// File: rtl/alb_mp_seq.sv
// Multi-precision issue/sequencer for the alb: one word pair per LOAD/ISSUE/SAMPLE/OUT pass,
// carry chained across words for add/sub. Define ALB_MP_PERF_EN to add the perf_words counter.
module alb_mp_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alb_mp_seq_if.slave           bus,
  output logic [DATA_WIDTH-1:0] alb_a,
  output logic [DATA_WIDTH-1:0] alb_b,
  output logic                  alb_ci,
  output logic [1:0]            alb_i,
  input  logic [DATA_WIDTH-1:0] alb_f,
  input  logic                  alb_co,
  input  logic                  alb_vo,
  input  logic                  alb_no,
  input  logic                  alb_zo
`ifdef ALB_MP_PERF_EN
  ,
  output logic [15:0]           perf_words
`endif
);
  localparam int WCNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] MAXW = WCNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, SAMPLE, OUT} state_t;

  state_t            state, state_n;
  logic [1:0]        op_r;
  logic              ci_r;
  logic [WCNT_W-1:0] cnt_r;
  logic [WCNT_W-1:0] idx_r;
  logic              zacc_r;
  logic              carry_r;
  logic              cmd_fire, opnd_fire, res_fire;

  function automatic logic [WCNT_W-1:0] clamp_words(input logic [WCNT_W-1:0] w);
    if (w == '0)
      return WCNT_W'(1);
    else if (w > MAXW)
      return MAXW;
    else
      return w;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_fire  = 1'b0;
    opnd_fire = 1'b0;
    res_fire  = 1'b0;
    case (state)
      IDLE: begin
        cmd_fire = bus.cmd_valid && bus.cmd_ready;
        if (cmd_fire) state_n = LOAD;
      end
      LOAD: begin
        opnd_fire = bus.opnd_valid && bus.opnd_ready;
        if (opnd_fire) state_n = ISSUE;
      end
      ISSUE:  state_n = SAMPLE;
      SAMPLE: state_n = OUT;
      OUT: begin
        res_fire = bus.res_valid && bus.res_ready;
        if (res_fire) state_n = bus.res_last ? IDLE : LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so each is high for exactly its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.cmd_ready  <= 1'b0;
      bus.opnd_ready <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_f      <= '0;
      bus.res_last   <= 1'b0;
      bus.res_co     <= 1'b0;
      bus.res_vo     <= 1'b0;
      bus.res_no     <= 1'b0;
      bus.res_zo     <= 1'b0;
      alb_a          <= '0;
      alb_b          <= '0;
      alb_ci         <= 1'b0;
      alb_i          <= '0;
      op_r           <= '0;
      ci_r           <= 1'b0;
      cnt_r          <= '0;
      idx_r          <= '0;
      zacc_r         <= 1'b0;
      carry_r        <= 1'b0;
    end else begin
      bus.cmd_ready  <= (state_n == IDLE);
      bus.opnd_ready <= (state_n == LOAD);
      bus.res_valid  <= (state_n == OUT);

      if (cmd_fire) begin
        op_r   <= bus.cmd_op;
        ci_r   <= bus.cmd_ci;
        cnt_r  <= clamp_words(bus.cmd_words);
        idx_r  <= '0;
        zacc_r <= 1'b1;
      end

      // Logic ops reuse the command carry on every word; add/sub chain from word 1 on
      if (opnd_fire) begin
        alb_a  <= bus.opnd_a;
        alb_b  <= bus.opnd_b;
        alb_i  <= op_r;
        alb_ci <= (idx_r == '0 || !op_r[0]) ? ci_r : carry_r;
      end

      if (state == SAMPLE) begin
        bus.res_f    <= alb_f;
        bus.res_co   <= alb_co;
        bus.res_vo   <= alb_vo;
        bus.res_no   <= alb_no;
        bus.res_zo   <= zacc_r & alb_zo;
        bus.res_last <= (idx_r == cnt_r - WCNT_W'(1));
        zacc_r       <= zacc_r & alb_zo;
        carry_r      <= alb_co;
      end

      if (res_fire && !bus.res_last) idx_r <= idx_r + WCNT_W'(1);
    end
  end

`ifdef ALB_MP_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_words <= '0;
    else if (bus.res_valid && bus.res_ready)
      perf_words <= sat_inc(perf_words);
  end
`endif
endmodule

// File: tb/tb_alb_mp_seq.sv
// Directed bench for alb_mp_seq: registered ALB stand-in, word-level expectation model,
// per-cycle compare process and literal checks of the documented scenarios.
module tb_alb_mp_seq;
  localparam int DW = 8;
  localparam int MW = 4;
  localparam int WW = $clog2(MW + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;

  alb_mp_seq_if #(.DATA_WIDTH(DW), .MAX_WORDS(MW)) bus ();

  logic [DW-1:0] alb_a, alb_b, alb_f;
  logic          alb_ci, alb_co, alb_vo, alb_no, alb_zo;
  logic [1:0]    alb_i;
`ifdef ALB_MP_PERF_EN
  logic [15:0]   perf_words;
`endif

  alb_mp_seq #(.DATA_WIDTH(DW), .MAX_WORDS(MW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .alb_a  (alb_a),
    .alb_b  (alb_b),
    .alb_ci (alb_ci),
    .alb_i  (alb_i),
    .alb_f  (alb_f),
    .alb_co (alb_co),
    .alb_vo (alb_vo),
    .alb_no (alb_no),
    .alb_zo (alb_zo)
`ifdef ALB_MP_PERF_EN
    ,
    .perf_words (perf_words)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ci;
    logic [1:0]    i;
  } alb_exp_t;

  typedef struct packed {
    logic [DW-1:0] f;
    logic          co;
    logic          vo;
    logic          no;
    logic          zo;
    logic          last;
  } res_exp_t;

  alb_exp_t alb_q[$];
  res_exp_t res_q[$];
  res_exp_t res_log[$];
  logic     ci_log[$];
  logic [DW-1:0] a_v [MW];
  logic [DW-1:0] b_v [MW];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int hs_count = 0;
  logic opnd_hs_d = 1'b0;
  logic rv_d = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ALB function set: 00 AND, 01 ADD, 10 OR, 11 SUB (a + ~b + ci); returns {f, co, vo, no, zo}
  function automatic logic [DW+3:0] alb_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic ci, input logic [1:0] i);
    logic [DW:0]   s;
    logic [DW-1:0] bb, f;
    logic          co, vo;
    co = 1'b0;
    vo = 1'b0;
    bb = (i == 2'b11) ? ~b : b;
    case (i)
      2'b00: f = a & b;
      2'b10: f = a | b;
      default: begin
        s  = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, ci};
        f  = s[DW-1:0];
        co = s[DW];
        vo = (a[DW-1] == bb[DW-1]) && (f[DW-1] != a[DW-1]);
      end
    endcase
    return {f, co, vo, f[DW-1], (f == '0)};
  endfunction

  // Registered ALB stand-in: inputs captured at an edge appear on the outputs after it
  always @(posedge clk)
    {alb_f, alb_co, alb_vo, alb_no, alb_zo} <= alb_fn(alb_a, alb_b, alb_ci, alb_i);

  function automatic int eff_words(input int w);
    return (w == 0) ? 1 : ((w > MW) ? MW : w);
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input logic ci, input int n);
    logic          carry, z, cin;
    logic [DW+3:0] r;
    alb_exp_t      x;
    res_exp_t      e;
    carry = ci;
    z     = 1'b1;
    for (int w = 0; w < n; w++) begin
      cin = (w == 0 || !op[0]) ? ci : carry;
      r   = alb_fn(a_v[w], b_v[w], cin, op);
      x   = {a_v[w], b_v[w], cin, op};
      alb_q.push_back(x);
      z      = z & r[0];
      e.f    = r[DW+3:4];
      e.co   = r[3];
      e.vo   = r[2];
      e.no   = r[1];
      e.zo   = z;
      e.last = (w == n - 1);
      res_q.push_back(e);
      carry = r[3];
    end
  endfunction

  initial begin : compare
    alb_exp_t x;
    res_exp_t e, d;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        opnd_hs_d = 1'b0;
        rv_d      = 1'b0;
        hs_count  = 0;
      end else begin
        if (opnd_hs_d) begin
          check("alb_expected", alb_q.size() != 0, 1);
          if (alb_q.size() != 0) begin
            x = alb_q.pop_front();
            check("alb_a", alb_a, x.a);
            check("alb_b", alb_b, x.b);
            check("alb_ci", alb_ci, x.ci);
            check("alb_i", alb_i, x.i);
            ci_log.push_back(alb_ci);
          end
        end
        if (bus.res_valid && !rv_d) check("res_latency", cyc - hs_cyc, 3);
        if (bus.res_valid) begin
          check("res_expected", res_q.size() != 0, 1);
          if (res_q.size() != 0) begin
            e = res_q[0];
            check("res_f", bus.res_f, e.f);
            check("res_co", bus.res_co, e.co);
            check("res_vo", bus.res_vo, e.vo);
            check("res_no", bus.res_no, e.no);
            check("res_zo", bus.res_zo, e.zo);
            check("res_last", bus.res_last, e.last);
            if (bus.res_ready) begin
              void'(res_q.pop_front());
              d = {bus.res_f, bus.res_co, bus.res_vo, bus.res_no, bus.res_zo, bus.res_last};
              res_log.push_back(d);
              hs_count++;
            end
          end
        end
        opnd_hs_d = bus.opnd_valid && bus.opnd_ready;
        if (opnd_hs_d) hs_cyc = cyc;
        rv_d = bus.res_valid;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic ci, input logic [WW-1:0] words);
    logic ok;
    ok = 1'b0;
    bus.cmd_op    = op;
    bus.cmd_ci    = ci;
    bus.cmd_words = words;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
    end
    check("cmd_accept", ok, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic send_opnd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic ok;
    ok = 1'b0;
    bus.opnd_a     = a;
    bus.opnd_b     = b;
    bus.opnd_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.opnd_ready;
    end
    check("opnd_accept", ok, 1);
    @(posedge clk);
    #1 bus.opnd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && res_q.size() != 0; t++) @(posedge clk);
    check("drain", res_q.size(), 0);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic ci, input logic [WW-1:0] words);
    int n;
    n = eff_words(int'(words));
    res_log.delete();
    ci_log.delete();
    model_cmd(op, ci, n);
    send_cmd(op, ci, words);
    for (int w = 0; w < n; w++) send_opnd(a_v[w], b_v[w]);
    wait_drain();
  endtask

  task automatic set_pair(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_v[k] = a;
    b_v[k] = b;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bool_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_opnd_ready", bus.opnd_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_f", bus.res_f, 0);
    check("rst_alb_a", alb_a, 0);
    check("rst_alb_ci", alb_ci, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 check("cmd_ready_after_reset", bus.cmd_ready, 1);

    // single-word add 7F + 01
    set_pair(0, 8'h7F, 8'h01);
    run_cmd(2'b01, 1'b0, WW'(1));
    check("t1_f", res_log[0].f, 8'h80);
    check("t1_vo", res_log[0].vo, 1);
    check("t1_no", res_log[0].no, 1);
    check("t1_co", res_log[0].co, 0);
    check("t1_zo", res_log[0].zo, 0);
    check("t1_last", res_log[0].last, 1);

    // 0x01FF + 0x0001
    set_pair(0, 8'hFF, 8'h01);
    set_pair(1, 8'h01, 8'h00);
    run_cmd(2'b01, 1'b0, WW'(2));
    check("t2_n", res_log.size(), 2);
    check("t2_f0", res_log[0].f, 8'h00);
    check("t2_co0", res_log[0].co, 1);
    check("t2_zo0", res_log[0].zo, 1);
    check("t2_last0", res_log[0].last, 0);
    check("t2_ci1", ci_log[1], 1);
    check("t2_f1", res_log[1].f, 8'h02);
    check("t2_co1", res_log[1].co, 0);
    check("t2_zo1", res_log[1].zo, 0);
    check("t2_last1", res_log[1].last, 1);

    // zero accumulation 0x0000 + 0x0000
    set_pair(0, 8'h00, 8'h00);
    set_pair(1, 8'h00, 8'h00);
    run_cmd(2'b01, 1'b0, WW'(2));
    check("t3_f0", res_log[0].f, 8'h00);
    check("t3_f1", res_log[1].f, 8'h00);
    check("t3_zo1", res_log[1].zo, 1);

    // logic op, ci=1 on every word, no chaining
    set_pair(0, 8'hF0, 8'h3C);
    set_pair(1, 8'h00, 8'hFF);
    set_pair(2, 8'hAA, 8'h55);
    run_cmd(2'b00, 1'b1, WW'(3));
    check("t4_n", res_log.size(), 3);
    check("t4_ci0", ci_log[0], 1);
    check("t4_ci1", ci_log[1], 1);
    check("t4_ci2", ci_log[2], 1);
    check("t4_f0", res_log[0].f, 8'h30);
    check("t4_last1", res_log[1].last, 0);
    check("t4_last2", res_log[2].last, 1);

    // cmd_words=0 runs exactly one word
    set_pair(0, 8'h12, 8'h34);
    run_cmd(2'b10, 1'b0, WW'(0));
    check("t5_n", res_log.size(), 1);
    check("t5_f", res_log[0].f, 8'h36);
    check("t5_last", res_log[0].last, 1);
    check("t5_idle", bus.cmd_ready, 1);

    // cmd_words=7 clamps to 4: 0xFFFFFFFF + 1
    set_pair(0, 8'hFF, 8'h01);
    set_pair(1, 8'hFF, 8'h00);
    set_pair(2, 8'hFF, 8'h00);
    set_pair(3, 8'hFF, 8'h00);
    run_cmd(2'b01, 1'b0, WW'(7));
    check("t6_n", res_log.size(), 4);
    check("t6_f3", res_log[3].f, 8'h00);
    check("t6_co3", res_log[3].co, 1);
    check("t6_zo3", res_log[3].zo, 1);
    check("t6_last3", res_log[3].last, 1);
    check("t6_idle", bus.cmd_ready, 1);

    // 0x0100 - 0x0001 with ci=1 meaning no borrow
    set_pair(0, 8'h00, 8'h01);
    set_pair(1, 8'h01, 8'h00);
    run_cmd(2'b11, 1'b1, WW'(2));
    check("t7_f0", res_log[0].f, 8'hFF);
    check("t7_co0", res_log[0].co, 0);
    check("t7_f1", res_log[1].f, 8'h00);
    check("t7_co1", res_log[1].co, 1);
    check("t7_zo1", res_log[1].zo, 0);

    // backpressure: result held 5 cycles, next operand waiting
    begin
      logic seen;
      seen = 1'b0;
      set_pair(0, 8'h10, 8'h20);
      set_pair(1, 8'h30, 8'h40);
      res_log.delete();
      model_cmd(2'b01, 1'b0, 2);
      bus.res_ready = 1'b0;
      send_cmd(2'b01, 1'b0, WW'(2));
      send_opnd(a_v[0], b_v[0]);
      bus.opnd_a     = a_v[1];
      bus.opnd_b     = b_v[1];
      bus.opnd_valid = 1'b1;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        seen = bus.res_valid;
      end
      check("bp_valid_seen", seen, 1);
      for (int k = 0; k < 5; k++) begin
        check("bp_res_valid", bus.res_valid, 1);
        check("bp_res_f", bus.res_f, 8'h30);
        check("bp_opnd_ready", bus.opnd_ready, 0);
        check("bp_alb_a", alb_a, 8'h10);
        check("bp_alb_b", alb_b, 8'h20);
        @(negedge clk);
      end
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        seen = bus.opnd_ready;
      end
      check("bp_opnd_resume", seen, 1);
      @(posedge clk);
      #1 bus.opnd_valid = 1'b0;
      wait_drain();
      check("bp_f1", res_log[1].f, 8'h70);
    end

    // reset during SAMPLE of word 1 of 2
    set_pair(0, 8'h01, 8'h02);
    set_pair(1, 8'h03, 8'h04);
    res_log.delete();
    model_cmd(2'b01, 1'b0, 2);
    send_cmd(2'b01, 1'b0, WW'(2));
    send_opnd(a_v[0], b_v[0]);
    for (int t = 0; t < 50 && res_q.size() != 1; t++) @(posedge clk);
    #1;
    send_opnd(a_v[1], b_v[1]);
    @(posedge clk);
    #1 reset = 1'b0;
    res_q.delete();
    alb_q.delete();
    #1;
    check("rr_res_valid", bus.res_valid, 0);
    check("rr_res_f", bus.res_f, 0);
    check("rr_res_last", bus.res_last, 0);
    check("rr_alb_a", alb_a, 0);
    check("rr_alb_b", alb_b, 0);
    check("rr_alb_ci", alb_ci, 0);
    check("rr_opnd_ready", bus.opnd_ready, 0);
    check("rr_cmd_ready", bus.cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 check("rr_cmd_ready_after", bus.cmd_ready, 1);

    set_pair(0, 8'hFF, 8'h01);
    set_pair(1, 8'h00, 8'h00);
    run_cmd(2'b01, 1'b0, WW'(2));
    check("t9_n", res_log.size(), 2);
    check("t9_ci0", ci_log[0], 0);
    check("t9_f0", res_log[0].f, 8'h00);
    check("t9_last0", res_log[0].last, 0);
    check("t9_f1", res_log[1].f, 8'h01);
    check("t9_last1", res_log[1].last, 1);

`ifdef ALB_MP_PERF_EN
    check("perf_words", perf_words, hs_count);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic bool_init();
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_ci     = 1'b0;
    bus.cmd_words  = '0;
    bus.opnd_valid = 1'b0;
    bus.opnd_a     = '0;
    bus.opnd_b     = '0;
    bus.res_ready  = 1'b1;
  endtask
endmodule
